// File: rtl/dose_alarm_scheduler_if.sv
// Bundle between the dose alarm scheduler and its surroundings:
// front-panel Control, patient ROM and the display/buzzer side.
interface dose_alarm_scheduler_if #(
  parameter int MISS_WIDTH = 4
);
  logic [3:0]            ctrl_state;
  logic [7:0]            patient_id;
  logic [23:0]           current_time;
  logic                  ack;
  logic [7:0]            rom_addr;
  logic [23:0]           rom_data;
  logic                  loaded;
  logic                  busy;
  logic                  alarm;
  logic [2:0]            dose_index;
  logic [MISS_WIDTH-1:0] missed_count;

  // Environment side: Control, ROM and clock drive, display observes.
  modport master (
    output ctrl_state, patient_id, current_time, ack, rom_data,
    input  rom_addr, loaded, busy, alarm, dose_index, missed_count
  );

  // Scheduler side.
  modport slave (
    input  ctrl_state, patient_id, current_time, ack, rom_data,
    output rom_addr, loaded, busy, alarm, dose_index, missed_count
  );
endinterface

// File: rtl/dose_alarm_scheduler.sv
// Dose alarm scheduler: loads a patient's dose times from ROM into a
// local table, then raises a held alarm when the live BCD time hits a
// valid slot. Doses falling due while an alarm is pending are counted.
//
//  state | meaning
//  IDLE  | table empty, waiting for a load command
//  FETCH | present rom_addr for the current slot
//  WAIT  | ROM latency countdown
//  STORE | capture rom_data into the current slot
//  READY | table complete, waiting for run (or reload)
//  RUN   | comparing live time against the table
module dose_alarm_scheduler #(
  parameter int NUM_DOSES   = 4,
  parameter int ROM_LATENCY = 2,
  parameter int MISS_WIDTH  = 4
) (
  input logic                  clk,
  input logic                  reset,
  dose_alarm_scheduler_if.slave bus
);

  localparam int IW = (NUM_DOSES > 1) ? $clog2(NUM_DOSES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DOSES - 1);
  localparam logic [23:0] EMPTY_SLOT = 24'hFFFFFF;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, STORE, READY, RUN} stateType;

  stateType state, nextState;

  logic [23:0]           slotTime [NUM_DOSES];
  logic [NUM_DOSES-1:0]  slotValid;
  logic [IW-1:0]         idx;
  logic [7:0]            base;
  logic [2:0]            waitCnt;
  logic [23:0]           timePrev;
  logic [7:0]            romAddr;
  logic                  loadedReg, busyReg, alarmReg;
  logic [2:0]            doseIdx;
  logic [MISS_WIDTH-1:0] missedCount;

  logic          doClear, startLoad, issueAddr, storeSlot, lastSlot, runMatch;
  logic          newSec, hit;
  logic [IW-1:0] hitIdx;

  assign newSec = (bus.current_time != timePrev);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state decode; a clear command overrides everything.
  always_comb begin
    nextState = state;
    if (bus.ctrl_state == 4'd0) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.ctrl_state == 4'd2) nextState = FETCH;
        FETCH:   nextState = WAIT;
        WAIT:    if (waitCnt == 3'd0) nextState = STORE;
        STORE:   nextState = lastSlot ? READY : FETCH;
        READY: begin
          if (bus.ctrl_state == 4'd2)      nextState = FETCH;
          else if (bus.ctrl_state == 4'd3) nextState = RUN;
        end
        RUN:     nextState = RUN;
        default: nextState = IDLE;
      endcase
    end
  end

  // Per-state datapath strobes.
  always_comb begin
    doClear   = (bus.ctrl_state == 4'd0);
    lastSlot  = (idx == IDX_LAST);
    startLoad = !doClear && (state == IDLE || state == READY) && (bus.ctrl_state == 4'd2);
    issueAddr = !doClear && (state == FETCH);
    storeSlot = !doClear && (state == STORE);
    runMatch  = !doClear && (state == RUN) && newSec && hit;
  end

  // Lowest-numbered valid slot matching the live time.
  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    for (int i = NUM_DOSES - 1; i >= 0; i--) begin
      if (slotValid[i] && (slotTime[i] == bus.current_time)) begin
        hit    = 1'b1;
        hitIdx = IW'(i);
      end
    end
  end

  // Datapath: table load, ROM addressing, alarm and missed-dose tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DOSES; i++) slotTime[i] <= EMPTY_SLOT;
      slotValid   <= '0;
      idx         <= '0;
      base        <= '0;
      waitCnt     <= '0;
      timePrev    <= '0;
      romAddr     <= '0;
      loadedReg   <= 1'b0;
      busyReg     <= 1'b0;
      alarmReg    <= 1'b0;
      doseIdx     <= '0;
      missedCount <= '0;
    end else begin
      timePrev <= bus.current_time;
      if (doClear) begin
        slotValid   <= '0;
        idx         <= '0;
        loadedReg   <= 1'b0;
        busyReg     <= 1'b0;
        alarmReg    <= 1'b0;
        missedCount <= '0;
      end else begin
        if (startLoad) begin
          base <= 8'(bus.patient_id * NUM_DOSES);
          idx  <= '0;
        end
        if (issueAddr) begin
          romAddr   <= base + 8'(idx);
          busyReg   <= 1'b1;
          loadedReg <= 1'b0;
          waitCnt   <= 3'(ROM_LATENCY - 1);
        end
        if (state == WAIT && waitCnt != 3'd0) waitCnt <= waitCnt - 3'd1;
        if (storeSlot) begin
          slotTime[idx]  <= bus.rom_data;
          slotValid[idx] <= (bus.rom_data != EMPTY_SLOT);
          if (lastSlot) begin
            loadedReg <= 1'b1;
            busyReg   <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        // A match with a simultaneous ack re-arms on the new slot instead of counting a miss.
        if (runMatch) begin
          if (alarmReg && !bus.ack) begin
            if (missedCount != '1) missedCount <= missedCount + 1'b1;
          end else begin
            alarmReg <= 1'b1;
            doseIdx  <= 3'(hitIdx);
          end
        end else if (bus.ack) begin
          alarmReg <= 1'b0;
        end
      end
    end
  end

  assign bus.rom_addr     = romAddr;
  assign bus.loaded       = loadedReg;
  assign bus.busy         = busyReg;
  assign bus.alarm        = alarmReg;
  assign bus.dose_index   = doseIdx;
  assign bus.missed_count = missedCount;

endmodule
